// File: rtl/decoder2to4_pkg.sv
// Shared definitions for the round-robin arbiter driving the 2-to-4 decoded select fabric.
package decoder2to4_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/decoder2to4_df.sv
// Dataflow 2-to-4 decoder: exactly one of Y0..Y3 is high for each Sel1:Sel0 code.
module decoder2to4_df (
   input  logic Sel0,
   input  logic Sel1,
   output logic Y0,
   output logic Y1,
   output logic Y2,
   output logic Y3
);

   assign Y0 = ~Sel1 & ~Sel0;
   assign Y1 = ~Sel1 &  Sel0;
   assign Y2 =  Sel1 & ~Sel0;
   assign Y3 =  Sel1 &  Sel0;

endmodule

// File: rtl/decoder2to4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one decoded resource; grants are held
// until the owner drops its request or MAX_HOLD cycles elapse.
module decoder2to4_rr_arbiter
   import decoder2to4_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_id,
   output logic               grant_valid,
   output logic               expired
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
   logic [IDX_W-1:0]   id_nxt;
   logic               valid_nxt;
   logic               exp_nxt;
   logic               rel_norm;
   logic               rel_force;
   logic               y0, y1, y2, y3;

   // Rotate req so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [IDX_W-1:0]     off;
      dbl = {r, r};
      rot = NUM_REQ'(dbl >> p);
      off = '0;
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         if (rot[i-1]) off = IDX_W'(i - 1);
      end
      return p + off;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         expired     <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         hold_cnt    <= cnt_nxt;
         grant_id    <= id_nxt;
         grant_valid <= valid_nxt;
         expired     <= exp_nxt;
      end
   end

   assign rel_norm  = ~req[grant_id];
   assign rel_force = (hold_cnt == CNT_W'(MAX_HOLD));

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = hold_cnt;
      id_nxt    = grant_id;
      valid_nxt = grant_valid;
      exp_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en && (|req)) begin
               id_nxt    = rr_pick(req, ptr);
               valid_nxt = 1'b1;
               cnt_nxt   = CNT_W'(1);
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (rel_norm || rel_force) begin
               valid_nxt = 1'b0;
               state_nxt = ST_IDLE;
               ptr_nxt   = grant_id + IDX_W'(1);
               cnt_nxt   = '0;
               // A simultaneous normal release takes precedence, so no expiry pulse.
               exp_nxt   = ~rel_norm;
            end else begin
               cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   decoder2to4_df u_dec (
      .Sel0 (grant_id[0]),
      .Sel1 (grant_id[1]),
      .Y0   (y0),
      .Y1   (y1),
      .Y2   (y2),
      .Y3   (y3)
   );

   always_comb begin
      grant = {y3, y2, y1, y0} & {NUM_REQ{grant_valid}};
   end

endmodule

// File: doc/decoder2to4_rr_arbiter.md
Name: decoder2to4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2-to-4 decoded resource (four one-hot select lines) among four requesters.
- Picks a winner by rotating priority and registers its 2-bit index.
- Drives the one-hot grant through a 2-to-4 decoder instance.
- Holds each grant until the requester releases it or a hold limit expires; sits between requesting agents and the decoded select fabric.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; low blocks new grants but does not cut a current grant.
- req  input  4  request vector; bit i = requester i.
- grant  output  4  one-hot grant, produced by the 2-to-4 decoder from grant_id, gated by grant_valid; 4'b0000 when no grant.
- grant_id  output  2  index of current or last winner.
- grant_valid  output  1  a grant is active.
- expired  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state (async, also mid-operation):
  - state=IDLE, ptr=2'd0, hold_cnt=0.
  - grant=4'b0000, grant_id=2'd0, grant_valid=0, expired=0.
  - Any active grant drops immediately on rst_n assertion.
- States: IDLE, BUSY.
- IDLE:
  - If en=1 and req!=0, scan req starting at ptr, ascending with wrap 3->0; the first set bit wins.
  - On that edge: grant_id<=winner, grant_valid<=1, hold_cnt<=1, state<=BUSY.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N gives grant visible after edge N (one registered cycle).
- BUSY:
  - grant stays constant.
  - Release condition, evaluated each edge:
    - (a) req[grant_id]==0, normal release; or
    - (b) hold_cnt==MAX_HOLD, forced release.
  - On release:
    - grant_valid<=0, state<=IDLE.
    - ptr<=grant_id+1 mod 4 (3 wraps to 0).
    - hold_cnt<=0.
    - expired<=1 only for (b) when req[grant_id] is still 1.
  - Otherwise hold_cnt<=hold_cnt+1. The counter never exceeds MAX_HOLD, so it cannot wrap.
  - (a) and (b) together in one cycle: treat as normal release, expired=0.
- Handoff gap: exactly one cycle with grant=0 between consecutive grants. This is guaranteed no-overlap for the decoded resource.
- en:
  - Sampled only in IDLE.
  - en falling during BUSY has no effect until release.
  - en low in IDLE keeps grant=0 and leaves ptr unchanged.
- Fairness:
  - The just-served requester has lowest priority next round.
  - With all four requesting continuously, the grant order is 0,1,2,3,0...
- Preempted requester (forced release) re-enters arbitration as lowest priority. It is not re-granted while others are requesting.
- MAX_HOLD=1: every grant lasts exactly one cycle. expired pulses on each release where the request is still held.
- A req bit that pulses only in a BUSY cycle is not remembered; requests are level-sensitive.
- expired is registered, high for exactly one cycle, and coincides with the first grant_valid=0 cycle.

Decomposition:
- Shared package decoder2to4_pkg:
  - state encoding localparams: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - NUM_REQ=4.
  - IDX_W=2.
- Sub-module: the existing dataflow 2-to-4 decoder (decoder2to4_df), instantiated once.
  - Inputs: Sel0=grant_id[0], Sel1=grant_id[1].
  - Outputs Y0..Y3 are ANDed with grant_valid to form grant[0..3].
- Priority scan: combinational function in the arbiter (rotate by ptr, find first set bit, rotate back). No separate module.

Test Plan:
- Reset and idle: rst_n=0 for 3 cycles, req=4'b1111 -> grant=0, grant_valid=0, expired=0. Release rst_n with req=4'b0100 -> after 1 edge grant=4'b0100, grant_id=2.
- Round-robin rotation: req=4'b1111 held for a long period, MAX_HOLD=8 -> grants 0001,0010,0100,1000,0001, each 8 cycles wide, separated by one grant=0 cycle; expired pulses at every handoff.
- Normal release and wrap: grant to req3, then drop req[3] while req=4'b0011 -> one gap cycle, then grant=4'b0001 (ptr wrapped 3->0), expired stays 0.
- Timeout preemption: MAX_HOLD=4, only req[1]=1 continuously -> grant 0010 for 4 cycles, expired=1 for one cycle, gap, then 0010 again. Add req[2]=1 -> after next expiry, grant goes to 0100 before 0010.
- Enable gating: en=0, req=4'b1000 -> no grant. Set en=1 -> grant=1000 next edge. Drop en during BUSY -> grant persists until req[3] drops.
- Async reset mid-grant: grant=0100 active, assert rst_n low between clock edges -> grant=0 immediately, ptr=0. After release with req=4'b1111 -> first grant=0001.
